// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding load/store sequencer in front of a BRAM that
// has a registered 1-cycle read port and a level-sensitive write enable.
// Optional store-to-load forwarding is built when MEM_CTRL_FWD_EN is defined.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, and request inputs are
// ignored in every other state. rsp_valid is a one-cycle pulse with no
// backpressure; the CPU must take it in that cycle.
module mem_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [BUS_WIDTH-1:0]  mem_addr_rd,
    output logic [BUS_WIDTH-1:0]  mem_addr_wr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_data_rd,
    output logic [2:0]            dbg_state
);

    // IDLE is encoded as 0 so the debug view reads 0 whenever the block rests.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RESP     = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
`ifdef MEM_CTRL_FWD_EN
        ,
        FWD      = 3'd6
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]  mem_addr_rd_q, mem_addr_rd_d;
    logic [BUS_WIDTH-1:0]  mem_addr_wr_q, mem_addr_wr_d;
    logic [DATA_WIDTH-1:0] mem_data_wr_q, mem_data_wr_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  rsp_valid_q, rsp_valid_d;

`ifdef MEM_CTRL_FWD_EN
    logic                  fwd_valid_q, fwd_valid_d;
    logic [BUS_WIDTH-1:0]  fwd_addr_q, fwd_addr_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_WIDTH-1:0] fwd_rsp_q, fwd_rsp_d;
`endif

    // Next-state and next-output logic; every mem_* pin is a flop output so
    // nothing from req_* reaches the RAM combinationally.
    always_comb begin
        state_d       = state_q;
        mem_addr_rd_d = mem_addr_rd_q;
        mem_addr_wr_d = mem_addr_wr_q;
        mem_data_wr_d = mem_data_wr_q;
        mem_rd_en_d   = 1'b0;
        mem_wr_en_d   = 1'b0;
        rsp_valid_d   = 1'b0;
`ifdef MEM_CTRL_FWD_EN
        fwd_valid_d   = fwd_valid_q;
        fwd_addr_d    = fwd_addr_q;
        fwd_data_d    = fwd_data_q;
        fwd_rsp_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        // Write address/data change only on this edge and
                        // stay put across the whole write pulse.
                        state_d       = WR_SETUP;
                        mem_addr_wr_d = req_addr;
                        mem_data_wr_d = req_wdata;
                    end else begin
`ifdef MEM_CTRL_FWD_EN
                        if (fwd_valid_q && (fwd_addr_q == req_addr)) begin
                            state_d     = FWD;
                            rsp_valid_d = 1'b1;
                            fwd_rsp_d   = fwd_data_q;
                        end else begin
                            state_d       = RD;
                            mem_rd_en_d   = 1'b1;
                            mem_addr_rd_d = req_addr;
                        end
`else
                        state_d       = RD;
                        mem_rd_en_d   = 1'b1;
                        mem_addr_rd_d = req_addr;
`endif
                    end
                end
            end
            RD: begin
                // RAM captures the read this edge; its data is valid in RESP.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            WR_SETUP: begin
                state_d     = WR_PULSE;
                mem_wr_en_d = 1'b1;
            end
            WR_PULSE: begin
                state_d     = WR_HOLD;
                rsp_valid_d = 1'b1;
`ifdef MEM_CTRL_FWD_EN
                fwd_valid_d = 1'b1;
                fwd_addr_d  = mem_addr_wr_q;
                fwd_data_d  = mem_data_wr_q;
`endif
            end
            WR_HOLD: begin
                state_d = IDLE;
            end
`ifdef MEM_CTRL_FWD_EN
            FWD: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops the write enable at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            mem_addr_rd_q <= '0;
            mem_addr_wr_q <= '0;
            mem_data_wr_q <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
`ifdef MEM_CTRL_FWD_EN
            fwd_valid_q   <= 1'b0;
            fwd_addr_q    <= '0;
            fwd_data_q    <= '0;
            fwd_rsp_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mem_addr_rd_q <= mem_addr_rd_d;
            mem_addr_wr_q <= mem_addr_wr_d;
            mem_data_wr_q <= mem_data_wr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            rsp_valid_q   <= rsp_valid_d;
`ifdef MEM_CTRL_FWD_EN
            fwd_valid_q   <= fwd_valid_d;
            fwd_addr_q    <= fwd_addr_d;
            fwd_data_q    <= fwd_data_d;
            fwd_rsp_q     <= fwd_rsp_d;
`endif
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = ~req_ready;
    assign rsp_valid   = rsp_valid_q;
    assign mem_addr_rd = mem_addr_rd_q;
    assign mem_addr_wr = mem_addr_wr_q;
    assign mem_data_wr = mem_data_wr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign dbg_state   = state_q;

    // Load data passes straight from the RAM's output register during RESP;
    // a store ack (and idle) reads as 0, a forwarded load as the saved data.
`ifdef MEM_CTRL_FWD_EN
    assign rsp_rdata = (state_q == RESP) ? mem_data_rd : fwd_rsp_q;
`else
    assign rsp_rdata = (state_q == RESP) ? mem_data_rd : '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl with a behavioural
// RAM, a reference model (expected memory image, last-store tracker, expected
// response queue with due cycle) and per-scenario tasks.
module tb_mem_ctrl;

    localparam int BW = 8;
    localparam int DW = 8;
`ifdef MEM_CTRL_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [BW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, busy, mem_rd_en, mem_wr_en;
    logic [DW-1:0] rsp_rdata, mem_data_wr;
    logic [DW-1:0] mem_data_rd = '0;
    logic [BW-1:0] mem_addr_rd, mem_addr_wr;
    logic [2:0]    dbg_state;

    mem_ctrl #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr), .mem_data_wr(mem_data_wr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_data_rd(mem_data_rd),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / counters ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int accepts  = 0;
    int rsp_cnt  = 0;
    int b2b_ready = 0;
    bit b2b_mode = 1'b0;
    int prev_acc_edge = -1;
    int prev_occ = 0;

    always @(posedge clk) edge_cnt++;

    // ---------------- behavioural RAM ----------------
    logic [DW-1:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (mem_wr_en) ram_mem[mem_addr_wr] <= mem_data_wr;
        if (mem_rd_en) mem_data_rd <= ram_mem[mem_addr_rd];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_mem [0:255];
    logic [BW-1:0] written_q[$];
    bit            last_valid = 1'b0;
    logic [BW-1:0] last_addr = '0;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    function automatic void model_reset();
        exp_q.delete();
        exp_cyc_q.delete();
        last_valid = 1'b0;
        prev_acc_edge = -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [DW-1:0] d;
        int c;
        if (n_rst) begin
            n_checks++;
            if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) begin
                n_fail++; $display("FAIL mutex: rd_en=%b wr_en=%b required not both 1", mem_rd_en, mem_wr_en);
            end else n_pass++;
            n_checks++;
            if (busy !== ~req_ready) begin
                n_fail++; $display("FAIL busy: busy=%b required %b", busy, ~req_ready);
            end else n_pass++;
            n_checks++;
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%0h at edge %0d, none required", rsp_rdata, edge_cnt);
                end else begin
                    d = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if (rsp_rdata !== d || edge_cnt != c) begin
                        n_fail++; $display("FAIL rsp: rdata=%0h cycle=%0d required rdata=%0h cycle=%0d", rsp_rdata, edge_cnt, d, c);
                    end else n_pass++;
                end
            end else begin
                if (rsp_rdata !== '0 || rsp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rdata_idle: rsp_valid=%b rdata=%0h required 0/0", rsp_valid, rsp_rdata);
                end else n_pass++;
            end
            if (b2b_mode && req_ready === 1'b1) b2b_ready++;
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge of cycle 0 of the request.
    task automatic issue(input logic we, input logic [BW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit hold_valid);
        int guard = 0;
        int lat, occ;
        logic [DW-1:0] d;
        bit found;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, guard);
            req_valid = 1'b0;
            return;
        end else n_pass++;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (we) begin
            lat = 2; occ = 3; d = '0;
            exp_mem[addr] = wdata;
            found = 1'b0;
            foreach (written_q[i]) if (written_q[i] == addr) found = 1'b1;
            if (!found) written_q.push_back(addr);
            last_valid = 1'b1;
            last_addr  = addr;
        end else if (FWD_ON && last_valid && last_addr == addr) begin
            lat = 0; occ = 1; d = exp_mem[addr];
        end else begin
            lat = 1; occ = 2; d = exp_mem[addr];
        end
        exp_q.push_back(d);
        exp_cyc_q.push_back(edge_cnt + 1 + lat);
        if (b2b_mode && prev_acc_edge >= 0) begin
            n_checks++;
            if (edge_cnt + 1 - prev_acc_edge != prev_occ + 1) begin
                n_fail++; $display("FAIL spacing: %0d edges between accepts, required %0d", edge_cnt + 1 - prev_acc_edge, prev_occ + 1);
            end else n_pass++;
        end
        prev_acc_edge = edge_cnt + 1;
        prev_occ = occ;
        @(posedge clk);
        accepts++;
        @(negedge clk);
        if (!hold_valid) req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_rd_en, mem_wr_en, mem_addr_rd, mem_addr_wr, mem_data_wr} !== '0) begin
            n_fail++; $display("FAIL reset_mem: rd_en=%b wr_en=%b ard=%0h awr=%0h dwr=%0h required all 0",
                               mem_rd_en, mem_wr_en, mem_addr_rd, mem_addr_wr, mem_data_wr);
        end else n_pass++;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rsp: rsp_valid=%b rdata=%0h required 0/0", rsp_valid, rsp_rdata);
        end else n_pass++;
        n_rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_ready: ready=%b busy=%b state=%0d required 1/0/0", req_ready, busy, dbg_state);
        end else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int wr_cycles = 0;
        issue(1'b1, 8'h03, 8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_wr_en === 1'b1) wr_cycles++;
            n_checks++;
            if (mem_wr_en !== (k == 1) || rsp_valid !== (k == 2) || req_ready !== (k == 3) ||
                mem_addr_wr !== 8'h03 || mem_data_wr !== 8'hA5 || mem_rd_en !== 1'b0) begin
                n_fail++; $display("FAIL store_cycle%0d: wr_en=%b rsp=%b ready=%b awr=%0h dwr=%0h rd_en=%b required %b/%b/%b/03/a5/0",
                                   k, mem_wr_en, rsp_valid, req_ready, mem_addr_wr, mem_data_wr, mem_rd_en, k == 1, k == 2, k == 3);
            end else n_pass++;
        end
        n_checks++;
        if (wr_cycles != 1) begin
            n_fail++; $display("FAIL store_pulse_width: %0d cycles, required 1", wr_cycles);
        end else n_pass++;
        issue(1'b0, 8'h03, 8'h00, 1'b0);
`ifdef MEM_CTRL_FWD_EN
        n_checks++;
        if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL load_fwd_c0: rd_en=%b rsp=%b rdata=%0h required 0/1/a5", mem_rd_en, rsp_valid, rsp_rdata);
        end else n_pass++;
`else
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_addr_rd !== 8'h03 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_c0: rd_en=%b ard=%0h rsp=%b required 1/03/0", mem_rd_en, mem_addr_rd, rsp_valid);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL load_c1: rd_en=%b rsp=%b rdata=%0h required 0/1/a5", mem_rd_en, rsp_valid, rsp_rdata);
        end else n_pass++;
`endif
        drain();
    endtask

    task automatic test_forwarding();
        logic [DW-1:0] v2;
        v2 = DW'($urandom_range(0, 255));
        issue(1'b1, 8'h02, v2, 1'b0);
        issue(1'b1, 8'h01, 8'h5C, 1'b0);
        issue(1'b0, 8'h01, 8'h00, 1'b0);
        n_checks++;
`ifdef MEM_CTRL_FWD_EN
        if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'h5C) begin
            n_fail++; $display("FAIL fwd_hit: rd_en=%b rsp=%b rdata=%0h required 0/1/5c", mem_rd_en, rsp_valid, rsp_rdata);
        end else n_pass++;
`else
        if (mem_rd_en !== 1'b1 || mem_addr_rd !== 8'h01 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL ram_load_01: rd_en=%b ard=%0h rsp=%b required 1/01/0", mem_rd_en, mem_addr_rd, rsp_valid);
        end else n_pass++;
`endif
        issue(1'b0, 8'h02, 8'h00, 1'b0);
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_addr_rd !== 8'h02 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL miss_path: rd_en=%b ard=%0h rsp=%b required 1/02/0", mem_rd_en, mem_addr_rd, rsp_valid);
        end else n_pass++;
        drain();
    endtask

    task automatic test_addr_wrap();
        logic [DW-1:0] va, vb;
        va = DW'($urandom_range(0, 255));
        vb = DW'($urandom_range(0, 255));
        issue(1'b1, 8'hFF, va, 1'b0);
        issue(1'b1, 8'h00, vb, 1'b0);
        issue(1'b0, 8'hFF, 8'h00, 1'b0);
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_addr_rd !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_ff: rd_en=%b ard=%0h required 1/ff", mem_rd_en, mem_addr_rd);
        end else n_pass++;
        issue(1'b1, 8'h10, DW'($urandom_range(0, 255)), 1'b0);
        issue(1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_addr_rd !== 8'h00) begin
            n_fail++; $display("FAIL wrap_00: rd_en=%b ard=%0h required 1/00", mem_rd_en, mem_addr_rd);
        end else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int acc0, rsp0;
        logic [BW-1:0] a;
        @(posedge clk);
        b2b_mode = 1'b1;
        b2b_ready = 0;
        acc0 = accepts;
        rsp0 = rsp_cnt;
        prev_acc_edge = -1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                a = BW'($urandom_range(0, 255));
                issue(1'b1, a, DW'($urandom_range(0, 255)), 1'b1);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                issue(1'b0, a, DW'($urandom_range(0, 255)), 1'b1);
            end
        end
        b2b_mode = 1'b0;
        req_valid = 1'b0;
        drain();
        n_checks++;
        if (b2b_ready != accepts - acc0) begin
            n_fail++; $display("FAIL b2b_ready_accept: ready cycles=%0d accepts=%0d required equal", b2b_ready, accepts - acc0);
        end else n_pass++;
        n_checks++;
        if (rsp_cnt - rsp0 != 20 || accepts - acc0 != 20) begin
            n_fail++; $display("FAIL b2b_counts: responses=%0d accepts=%0d required 20/20", rsp_cnt - rsp0, accepts - acc0);
        end else n_pass++;
    endtask

    task automatic test_reset_wr_pulse();
        int guard = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (mem_wr_en !== 1'b1 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (mem_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL rst_wr_reach: wr_en=%b never reached, required 1", mem_wr_en);
        end else n_pass++;
        #1 n_rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (mem_wr_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr_drop: wr_en=%b rsp=%b required 0/0 before next edge", mem_wr_en, rsp_valid);
        end else n_pass++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL rst_wr_idle: ready=%b state=%0d required 1/0", req_ready, dbg_state);
        end else n_pass++;
        repeat (4) @(negedge clk);
        issue(1'b1, 8'h77, 8'hC3, 1'b0);
        issue(1'b0, 8'h77, 8'h00, 1'b0);
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store_load();
        test_forwarding();
        test_addr_wrap();
        test_back_to_back();
        test_reset_wr_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the CPU datapath and the BRAM-backed `ram` block. It accepts one load or store request at a time over a valid/ready handshake. It sequences the RAM's read-enable and write-enable pins so they are never asserted together, and it keeps write address and data stable around the level-sensitive write pulse. It returns load data, or a store acknowledge, as a single-cycle response pulse.

## Interface
Parameters come from `params.svh`; they are not overridden per instance.
- `BUS_WIDTH`, 8: address width; matches `ram`.
- `DATA_WIDTH`, 8: data width; matches `ram`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: CPU request present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in BUS_WIDTH: request address.
- `req_wdata` in DATA_WIDTH: store data.
- `req_ready` out 1: controller can accept a request.
- `rsp_valid` out 1: one-cycle response pulse, for both load and store.
- `rsp_rdata` out DATA_WIDTH: load data; 0 when `rsp_valid`=0 or for a store ack.
- `busy` out 1: equals the inverse of `req_ready`.
- `mem_addr_rd` out BUS_WIDTH: to `ram.addr_rd`.
- `mem_addr_wr` out BUS_WIDTH: to `ram.addr_wr`.
- `mem_data_wr` out DATA_WIDTH: to `ram.data_wr`.
- `mem_rd_en` out 1: to `ram.rd_en`.
- `mem_wr_en` out 1: to `ram.wr_en`.
- `mem_data_rd` in DATA_WIDTH: from `ram.data_rd`, which is registered with 1-cycle latency.

## Operation
- States: IDLE, RD, RESP, WR_SETUP, WR_PULSE, WR_HOLD, and FWD (FWD only with the macro enabled).
- Request acceptance:
  - A request is accepted on a rising edge where `req_valid`=1 and `req_ready`=1.
  - `req_ready`=1 only in IDLE.
  - `req_addr` and `req_wdata` are latched on acceptance. Request inputs are ignored in every other state.
- Load path: IDLE → RD → RESP → IDLE.
  - RD: `mem_rd_en`=1 and `mem_addr_rd` = latched address.
  - RESP: `rsp_valid`=1 and `rsp_rdata` = `mem_data_rd`.
- Store path: IDLE → WR_SETUP → WR_PULSE → WR_HOLD → IDLE.
  - `mem_addr_wr` and `mem_data_wr` are registered and change only on the edge entering WR_SETUP.
  - `mem_wr_en`=1 only in WR_PULSE.
  - WR_HOLD asserts `rsp_valid`=1 with `rsp_rdata`=0.
- Mutual exclusion: `mem_rd_en` and `mem_wr_en` are never 1 in the same cycle. This is a bench assertion.
- Both enables are registered outputs. No combinational path exists from `req_*` to `mem_*`.
- In IDLE, `mem_addr_rd`, `mem_addr_wr` and `mem_data_wr` hold their last values, and both enables are 0.

## Timing
- Cycle k is the interval following rising edge k. The request is accepted at edge 0.
- Load:
  - Cycle 0: RD, `mem_rd_en`=1.
  - Cycle 1: RESP, `rsp_valid`=1, data valid.
  - Cycle 2: IDLE, `req_ready`=1.
  - Load-to-response latency is 1 cycle; occupancy is 2 cycles.
- Store:
  - Cycle 0: WR_SETUP.
  - Cycle 1: WR_PULSE, `mem_wr_en`=1.
  - Cycle 2: WR_HOLD, ack.
  - Cycle 3: IDLE.
- Back-to-back requests: the next request can be accepted at the edge that ends the cycle in which `req_ready` returns to 1. The minimum request spacing is therefore 3 edges for a load and 4 edges for a store.
- `rsp_valid` has no backpressure. The CPU must consume it in that cycle.
- Reset values (asynchronous on `n_rst`=0):
  - State is IDLE.
  - All `mem_*` outputs are 0.
  - `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=1 once `n_rst`=1.
  - The forwarding entry is invalid.
- Reset mid-store:
  - `mem_wr_en` drops immediately, without waiting for an edge.
  - The RAM location may or may not hold the new data; this is accepted behaviour.
  - No ack is issued.
- Reset mid-load: no response is issued.

## Configuration
- `MEM_CTRL_FWD_EN` defined:
  - A last-write register holds the address and data of the most recent store, plus a valid bit.
  - The entry is set on the edge entering WR_HOLD and invalidated by reset.
  - A load whose address matches a valid entry goes IDLE → FWD → IDLE. In FWD, `rsp_valid`=1 and `rsp_rdata` = forwarded data, and `mem_rd_en` stays 0. Load latency is 0 cycles after acceptance (response in cycle 0); occupancy is 1 cycle.
- `MEM_CTRL_FWD_EN` undefined:
  - There is no FWD state and no last-write register.
  - Every load takes the RAM path.

## Test plan
- Reset release: hold `n_rst`=0 for 3 cycles, then release. Required: all `mem_*` outputs 0, `rsp_valid`=0, `req_ready`=1.
- Store then load, macro off:
  - Store 0xA5 to address 0x03. Required: `mem_wr_en`=1 for exactly 1 cycle with `mem_addr_wr`=0x03 and `mem_data_wr`=0xA5, and the ack arrives in cycle 2.
  - Then load 0x03. Required: `mem_rd_en`=1 in cycle 0, and `rsp_rdata`=0xA5 with `rsp_valid`=1 in cycle 1.
- Back-to-back alternating traffic: hold `req_valid`=1 continuously for 20 requests.
  - Required: `mem_rd_en` and `mem_wr_en` are never 1 together.
  - Required: every `req_ready`=1 cycle ends with an acceptance at the following edge.
  - Required: the response count equals the accept count.
- Reset during WR_PULSE: assert `n_rst`=0 while `mem_wr_en`=1. Required: `mem_wr_en` is 0 within the same cycle, no ack is issued, and the controller is in IDLE after release.
- Forwarding, macro on:
  - Store 0x5C to address 0x01, then load 0x01. Required: `rsp_valid`=1 with 0x5C in cycle 0 and `mem_rd_en` stays 0.
  - Then load 0x02. Required: the normal RAM path is taken.
- Address wrap: store and then load address 0xFF, and store and then load address 0x00. Required: both complete on the normal path and each returns its stored value.
